mem_waitstate_ctrl: RTL and testbench

MEM_WAITSTATE_CTRL -- requirements
Module: mem_waitstate_ctrl

---
 rtl/gba_mem_pkg.sv | 69 ++++++
 rtl/mem_region_decode.sv | 36 +++
 rtl/mem_waitstate_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_waitstate_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/gba_mem_pkg.sv
// ----------------------------------------------------------------------------
// gba_mem_pkg : shared region, access-size and WAITCNT definitions | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gba_mem_pkg;

  typedef enum logic [3:0] {
    REG_BIOS,
    REG_EWRAM,
    REG_IWRAM,
    REG_IO,
    REG_PAL,
    REG_VRAM,
    REG_OAM,
    REG_WS0,
    REG_WS1,
    REG_WS2,
    REG_SRAM,
    REG_UNMAPPED
  } mem_region_e;

  // Region base values of addr[27:24]; each WSx spans base and base+1
  localparam logic [3:0] BASE_BIOS  = 4'h0;
  localparam logic [3:0] BASE_EWRAM = 4'h2;
  localparam logic [3:0] BASE_IWRAM = 4'h3;
  localparam logic [3:0] BASE_IO    = 4'h4;
  localparam logic [3:0] BASE_PAL   = 4'h5;
  localparam logic [3:0] BASE_VRAM  = 4'h6;
  localparam logic [3:0] BASE_OAM   = 4'h7;
  localparam logic [3:0] BASE_WS0   = 4'h8;
  localparam logic [3:0] BASE_WS1   = 4'hA;
  localparam logic [3:0] BASE_WS2   = 4'hC;
  localparam logic [3:0] BASE_SRAM  = 4'hE;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
  localparam logic [1:0] MEM_SIZE_RSVD = 2'd3;

  localparam int WC_SRAM_LSB  = 0;
  localparam int WC_WS0_N_LSB = 2;
  localparam int WC_WS0_S     = 4;
  localparam int WC_WS1_N_LSB = 5;
  localparam int WC_WS1_S     = 7;
  localparam int WC_WS2_N_LSB = 8;
  localparam int WC_WS2_S     = 10;

  function automatic logic [4:0] n_waits(input logic [1:0] field);
    case (field)
      2'd0:    return 5'd4;
      2'd1:    return 5'd3;
      2'd2:    return 5'd2;
      default: return 5'd8;
    endcase
  endfunction

  // Reserved size advances like a word so the tracker stays well defined
  function automatic logic [31:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_SIZE_BYTE: return 32'd1;
      MEM_SIZE_HALF: return 32'd2;
      default:       return 32'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_region_decode.sv
// ----------------------------------------------------------------------------
// mem_region_decode : addr[27:24] -> memory region and ROM flag | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_region_decode
  import gba_mem_pkg::*;
(
  input  logic [3:0]  page,
  output mem_region_e region,
  output logic        rom_region
);

  always_comb begin
    region = REG_UNMAPPED;
    case (page)
      BASE_BIOS:             region = REG_BIOS;
      BASE_EWRAM:            region = REG_EWRAM;
      BASE_IWRAM:            region = REG_IWRAM;
      BASE_IO:               region = REG_IO;
      BASE_PAL:              region = REG_PAL;
      BASE_VRAM:             region = REG_VRAM;
      BASE_OAM:              region = REG_OAM;
      BASE_WS0, 4'h9:        region = REG_WS0;
      BASE_WS1, 4'hB:        region = REG_WS1;
      BASE_WS2, 4'hD:        region = REG_WS2;
      BASE_SRAM:             region = REG_SRAM;
      default:               region = REG_UNMAPPED;
    endcase
  end

  assign rom_region = (region == REG_WS0) || (region == REG_WS1) || (region == REG_WS2);

endmodule

`default_nettype wire

// File: rtl/mem_waitstate_ctrl.sv
// ----------------------------------------------------------------------------
// mem_waitstate_ctrl : CPU bus wait-state insertion and abort flag | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_waitstate_ctrl
  import gba_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        write,
  input  logic        valid,
  input  logic        cfg_we,
  input  logic [15:0] cfg_wdata,
  output logic        pause,
  output logic        abort,
  output logic [15:0] waitcnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  r_state;
  logic [4:0]  r_cnt;
  logic [15:0] r_waitcnt;
  logic [31:0] r_prev_addr;
  logic [1:0]  r_prev_size;
  mem_region_e r_prev_region;
  logic        r_abort;

  mem_region_e w_region;
  logic        w_rom;
  logic [15:0] w_wc;
  logic        w_accept;
  logic        w_seq;
  logic        w_illegal;
  logic [4:0]  w_n;
  logic [4:0]  w_s;
  logic [4:0]  w_wait;

  mem_region_decode u_decode (
    .page       (addr[27:24]),
    .region     (w_region),
    .rom_region (w_rom)
  );

  // A same-cycle config write is already visible to the access it accompanies
  assign w_wc      = cfg_we ? cfg_wdata : r_waitcnt;
  assign w_accept  = valid && (r_state == ST_IDLE);
  assign w_seq     = w_rom && (w_region == r_prev_region)
                     && (addr == r_prev_addr + size_bytes(r_prev_size));
  assign w_illegal = (write && (w_rom || (w_region == REG_BIOS)))
                     || (size == MEM_SIZE_RSVD);

  always_comb begin
    w_n = 5'd0;
    w_s = 5'd0;
    case (w_region)
      REG_WS0: begin
        w_n = n_waits(w_wc[WC_WS0_N_LSB +: 2]);
        w_s = w_wc[WC_WS0_S] ? 5'd1 : 5'd2;
      end
      REG_WS1: begin
        w_n = n_waits(w_wc[WC_WS1_N_LSB +: 2]);
        w_s = w_wc[WC_WS1_S] ? 5'd1 : 5'd4;
      end
      REG_WS2: begin
        w_n = n_waits(w_wc[WC_WS2_N_LSB +: 2]);
        w_s = w_wc[WC_WS2_S] ? 5'd1 : 5'd8;
      end
      default: begin
        w_n = 5'd0;
        w_s = 5'd0;
      end
    endcase
  end

  // Word accesses on the 16-bit ROM bus need a second, always sequential, half
  always_comb begin
    w_wait = 5'd0;
    case (w_region)
      REG_EWRAM: w_wait = (size == MEM_SIZE_WORD) ? 5'd4 : 5'd2;
      REG_SRAM:  w_wait = n_waits(w_wc[WC_SRAM_LSB +: 2]);
      REG_WS0, REG_WS1, REG_WS2:
        w_wait = (w_seq ? w_s : w_n) + ((size == MEM_SIZE_WORD) ? w_s : 5'd0);
      default:   w_wait = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 5'd0;
      r_waitcnt     <= 16'h0000;
      r_prev_addr   <= 32'hFFFF_FFFF;
      r_prev_size   <= MEM_SIZE_BYTE;
      r_prev_region <= REG_UNMAPPED;
      r_abort       <= 1'b0;
    end else begin
      if (cfg_we) begin
        r_waitcnt <= cfg_wdata;
      end
      r_abort <= w_accept && w_illegal;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          r_prev_addr   <= addr;
          r_prev_size   <= size;
          r_prev_region <= w_region;
          if (w_wait != 5'd0) begin
            r_state <= ST_WAIT;
            r_cnt   <= w_wait;
          end
        end
      end else begin
        if (r_cnt == 5'd1) begin
          r_state <= ST_IDLE;
          r_cnt   <= 5'd0;
        end else begin
          r_cnt <= r_cnt - 5'd1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && w_accept && (w_region == REG_UNMAPPED)) begin
      $warning("mem_waitstate_ctrl: access to unmapped address %08h", addr);
    end
  end
`endif

  assign pause   = (r_state == ST_WAIT);
  assign abort   = r_abort;
  assign waitcnt = r_waitcnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_waitstate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_waitstate_ctrl : directed vector bench for mem_waitstate_ctrl | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_waitstate_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        write;
  logic        valid;
  logic        cfg_we;
  logic [15:0] cfg_wdata;
  logic        pause;
  logic        abort;
  logic [15:0] waitcnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        write;
    logic        cfg_we;
    logic [15:0] cfg_wdata;
    int          exp_pause;
    logic        exp_abort;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  mem_waitstate_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .size      (size),
    .write     (write),
    .valid     (valid),
    .cfg_we    (cfg_we),
    .cfg_wdata (cfg_wdata),
    .pause     (pause),
    .abort     (abort),
    .waitcnt   (waitcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic count_pause(output int cnt);
    cnt = 0;
    while (pause && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Called on a negedge; returns on a negedge one idle cycle after the stall
  task automatic do_access(input vec_t v, input string name);
    int cnt;
    addr = v.addr; size = v.size; write = v.write;
    cfg_we = v.cfg_we; cfg_wdata = v.cfg_wdata; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    chk({name, " abort"}, {31'd0, abort}, {31'd0, v.exp_abort});
    count_pause(cnt);
    chk({name, " pause_cycles"}, cnt, v.exp_pause);
    @(negedge clk);
    chk({name, " abort_clear"}, {31'd0, abort}, 32'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [1:0] s, input logic w,
                              input logic ce, input logic [15:0] cd, input int ep,
                              input logic ea);
    vec_t v;
    v.addr = a; v.size = s; v.write = w; v.cfg_we = ce; v.cfg_wdata = cd;
    v.exp_pause = ep; v.exp_abort = ea;
    return v;
  endfunction

  initial begin
    int cnt;
    vecs[0]  = mk(32'h0800_0000, 2'd1, 1'b0, 1'b0, 16'h0000,  4, 1'b0);
    vecs[1]  = mk(32'h0800_0000, 2'd1, 1'b0, 1'b1, 16'h0014,  3, 1'b0);
    vecs[2]  = mk(32'h0800_0002, 2'd1, 1'b0, 1'b0, 16'h0000,  1, 1'b0);
    vecs[3]  = mk(32'h0800_0004, 2'd2, 1'b0, 1'b0, 16'h0000,  2, 1'b0);
    vecs[4]  = mk(32'h0200_0000, 2'd2, 1'b0, 1'b0, 16'h0000,  4, 1'b0);
    vecs[5]  = mk(32'h0300_0000, 2'd2, 1'b0, 1'b0, 16'h0000,  0, 1'b0);
    vecs[6]  = mk(32'h0000_0010, 2'd2, 1'b1, 1'b0, 16'h0000,  0, 1'b1);
    vecs[7]  = mk(32'h0E00_0000, 2'd0, 1'b1, 1'b1, 16'h0003,  8, 1'b0);
    vecs[8]  = mk(32'h0200_0000, 2'd1, 1'b0, 1'b0, 16'h0000,  2, 1'b0);
    vecs[9]  = mk(32'h0100_0000, 2'd0, 1'b0, 1'b0, 16'h0000,  0, 1'b0);
    vecs[10] = mk(32'h0300_0000, 2'd3, 1'b0, 1'b0, 16'h0000,  0, 1'b1);
    vecs[11] = mk(32'h0C00_0000, 2'd2, 1'b0, 1'b1, 16'h0000, 12, 1'b0);
    vecs[12] = mk(32'h0C00_0004, 2'd2, 1'b0, 1'b0, 16'h0000, 16, 1'b0);
    vecs[13] = mk(32'h0A00_0000, 2'd1, 1'b1, 1'b0, 16'h0000,  4, 1'b1);
    vecs[14] = mk(32'h0A00_0002, 2'd1, 1'b0, 1'b1, 16'h0080,  1, 1'b0);
    vecs[15] = mk(32'h0800_0000, 2'd1, 1'b0, 1'b1, 16'h000C,  8, 1'b0);
    vecs[16] = mk(32'h0000_0000, 2'd1, 1'b0, 1'b0, 16'h0000,  0, 1'b0);
    vecs[17] = mk(32'h0E00_0000, 2'd0, 1'b0, 1'b0, 16'h0000,  4, 1'b0);
    vecs[18] = mk(32'h0F00_0000, 2'd0, 1'b0, 1'b0, 16'h0000,  0, 1'b0);

    rst_n = 1'b0; addr = 32'd0; size = 2'd0; write = 1'b0;
    valid = 1'b0; cfg_we = 1'b0; cfg_wdata = 16'h0000;
    #1;
    chk("reset pause",   {31'd0, pause}, 32'd0);
    chk("reset abort",   {31'd0, abort}, 32'd0);
    chk("reset waitcnt", {16'd0, waitcnt}, 32'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      do_access(vecs[i], $sformatf("vec%0d", i));
    end
    chk("waitcnt readback", {16'd0, waitcnt}, 32'h0000_000C);

    // Reset on the 2nd cycle of an 8-cycle WS0 stall
    addr = 32'h0800_0000; size = 2'd1; write = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("rst pre pause", {31'd0, pause}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst mid-wait pause",   {31'd0, pause}, 32'd0);
    chk("rst mid-wait waitcnt", {16'd0, waitcnt}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(mk(32'h0800_0002, 2'd1, 1'b0, 1'b0, 16'h0000, 4, 1'b0), "post-reset nonseq");

    // valid held high through the stall is only sampled once back in IDLE
    addr = 32'h0800_0004; size = 2'd1; write = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    count_pause(cnt);
    chk("held valid first burst", cnt, 2);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    count_pause(cnt);
    chk("held valid second burst", cnt, 4);
    @(negedge clk);

    // cfg write during a stall leaves the running count alone
    addr = 32'h0900_0000; size = 2'd1; write = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    cfg_we = 1'b1; cfg_wdata = 16'hF80C;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    cnt = 1;
    @(negedge clk);
    while (pause && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("cfg during wait pause_cycles", cnt, 4);
    chk("cfg during wait readback", {16'd0, waitcnt}, 32'h0000_F80C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
